// File: rtl/axi_slave_sync_fifo_pkg.sv
// Shared types for the AXI slave address-queue FIFO: per-cycle operation
// decode used by the pointer update logic.
package axi_slave_sync_fifo_pkg;

    typedef enum logic [2:0] {
        OP_IDLE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_BOTH = 3'd3,
        OP_CLR  = 3'd4
    } fifo_op_e;

    // Clear wins over any handshake that completes in the same cycle.
    function automatic fifo_op_e f_decode_op(
        input logic clr,
        input logic push,
        input logic pop
    );
        if (clr) begin
            return OP_CLR;
        end
        case ({push, pop})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_BOTH;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/axi_slave_sync_fifo.sv
// Single-clock first-word-fall-through FIFO queuing AW/AR words in the AXI
// slave model, with full/empty/item/room status.
module axi_slave_sync_fifo
    import axi_slave_sync_fifo_pkg::*;
#(
    parameter int FDW = 32,
    parameter int FAW = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    output logic           wr_rdy,
    input  logic           wr_vld,
    input  logic [FDW-1:0] wr_din,
    input  logic           rd_rdy,
    output logic           rd_vld,
    output logic [FDW-1:0] rd_dout,
    output logic           full,
    output logic           empty,
    output logic [FAW:0]   item_cnt,
    output logic [FAW:0]   room_cnt
);

    localparam int           DEPTH   = 1 << FAW;
    localparam logic [FAW:0] DEPTH_V = (FAW+1)'(DEPTH);

    // Handshake contract: a push completes on a rising edge where
    // wr_vld && wr_rdy; a pop completes where rd_rdy && rd_vld. wr_rdy and
    // rd_vld depend only on the pointers, never on wr_vld/rd_rdy.

    logic [FDW-1:0] r_mem [DEPTH];
    logic [FAW:0]   r_wptr;
    logic [FAW:0]   r_rptr;

    logic [FAW:0]   w_item_cnt;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    fifo_op_e       w_op;

    // Extra pointer bit separates full from empty when the indices match.
    assign w_item_cnt = r_wptr - r_rptr;
    assign w_full     = (w_item_cnt == DEPTH_V);
    assign w_empty    = (r_wptr == r_rptr);

    assign w_push = wr_vld && !w_full;
    assign w_pop  = rd_rdy && !w_empty;
    assign w_op   = f_decode_op(clr, w_push, w_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            case (w_op)
                OP_CLR: begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end
                OP_PUSH: r_wptr <= r_wptr + 1'b1;
                OP_POP:  r_rptr <= r_rptr + 1'b1;
                OP_BOTH: begin
                    r_wptr <= r_wptr + 1'b1;
                    r_rptr <= r_rptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (w_op == OP_PUSH || w_op == OP_BOTH) begin
            r_mem[r_wptr[FAW-1:0]] <= wr_din;
        end
    end

    assign rd_dout  = r_mem[r_rptr[FAW-1:0]];
    assign wr_rdy   = !w_full;
    assign rd_vld   = !w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign item_cnt = w_item_cnt;
    assign room_cnt = DEPTH_V - w_item_cnt;

endmodule

// File: tb/tb_axi_slave_sync_fifo.sv
// Directed self-checking bench for axi_slave_sync_fifo (FDW=32, FAW=4).
module tb_axi_slave_sync_fifo;

    localparam int FDW = 32;
    localparam int FAW = 4;

    logic           clk;
    logic           rstn;
    logic           clr;
    logic           wr_rdy;
    logic           wr_vld;
    logic [FDW-1:0] wr_din;
    logic           rd_rdy;
    logic           rd_vld;
    logic [FDW-1:0] rd_dout;
    logic           full;
    logic           empty;
    logic [FAW:0]   item_cnt;
    logic [FAW:0]   room_cnt;

    int n_checks;
    int n_fails;
    logic [FDW-1:0] exp_q[$];

    axi_slave_sync_fifo #(.FDW(FDW), .FAW(FAW)) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .wr_rdy   (wr_rdy),
        .wr_vld   (wr_vld),
        .wr_din   (wr_din),
        .rd_rdy   (rd_rdy),
        .rd_vld   (rd_vld),
        .rd_dout  (rd_dout),
        .full     (full),
        .empty    (empty),
        .item_cnt (item_cnt),
        .room_cnt (room_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input int cnt);
        check_eq({tag, "_cnt"},   32'(item_cnt), 32'(cnt));
        check_eq({tag, "_room"},  32'(room_cnt), 32'(16 - cnt));
        check_eq({tag, "_full"},  32'(full),     32'(cnt == 16));
        check_eq({tag, "_empty"}, 32'(empty),    32'(cnt == 0));
        check_eq({tag, "_wrdy"},  32'(wr_rdy),   32'(cnt != 16));
        check_eq({tag, "_rvld"},  32'(rd_vld),   32'(cnt != 0));
    endtask

    task automatic push_one(input logic [FDW-1:0] d);
        wr_vld = 1'b1;
        wr_din = d;
        tick();
        wr_vld = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic pop_check(input string tag);
        logic [FDW-1:0] e;
        e = exp_q.pop_front();
        check_eq({tag, "_vld"},  32'(rd_vld), 32'd1);
        check_eq({tag, "_data"}, rd_dout, e);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
    endtask

    task automatic push_pop(input logic [FDW-1:0] d, input string tag);
        logic [FDW-1:0] e;
        e = exp_q.pop_front();
        check_eq({tag, "_data"}, rd_dout, e);
        wr_vld = 1'b1;
        wr_din = d;
        rd_rdy = 1'b1;
        tick();
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        exp_q.push_back(d);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn   = 1'b0;
        clr    = 1'b0;
        wr_vld = 1'b0;
        wr_din = '0;
        rd_rdy = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check_status("rst", 0);

        // asynchronous reset mid-cycle discards stored entries at once
        push_one(32'h11);
        push_one(32'h22);
        check_status("pre_arst", 2);
        #3;
        rstn = 1'b0;
        #1;
        check_status("arst", 0);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        tick();

        // fill to full, ignored 17th push, drain in order
        for (int i = 1; i <= 16; i++) push_one(32'(i));
        check_status("fill", 16);
        wr_vld = 1'b1;
        wr_din = 32'hFF;
        tick();
        wr_vld = 1'b0;
        check_status("ovf", 16);
        for (int i = 1; i <= 16; i++) pop_check($sformatf("drain%0d", i));
        check_status("drained", 0);

        // fall-through head visible without a pop
        push_one(32'hA5);
        check_eq("ft_vld", 32'(rd_vld), 32'd1);
        check_eq("ft_data", rd_dout, 32'hA5);
        tick();
        tick();
        check_eq("ft_hold_data", rd_dout, 32'hA5);
        check_status("ft_hold", 1);
        pop_check("ft_pop");
        check_status("ft_empty", 0);

        // streaming push+pop at 3 entries across pointer wrap
        for (int i = 0; i < 3; i++) push_one(32'h100 + 32'(i));
        for (int i = 0; i < 40; i++) begin
            push_pop(32'h200 + 32'(i), $sformatf("strm%0d", i));
            check_eq($sformatf("strm%0d_cnt", i), 32'(item_cnt), 32'd3);
        end
        for (int i = 0; i < 3; i++) pop_check($sformatf("strm_tail%0d", i));
        check_status("strm_done", 0);

        // push+pop while full: only the pop happens
        for (int i = 0; i < 16; i++) push_one(32'h300 + 32'(i));
        check_status("full2", 16);
        check_eq("fullpp_head", rd_dout, 32'h300);
        wr_vld = 1'b1;
        wr_din = 32'hEE;
        rd_rdy = 1'b1;
        tick();
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        void'(exp_q.pop_front());
        check_status("fullpp", 15);
        for (int i = 0; i < 15; i++) pop_check($sformatf("fullpp_drain%0d", i));
        check_status("fullpp_done", 0);

        // push+pop while empty: only the push happens
        wr_vld = 1'b1;
        wr_din = 32'h5A;
        rd_rdy = 1'b1;
        tick();
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        exp_q.push_back(32'h5A);
        check_status("emptypp", 1);
        check_eq("emptypp_head", rd_dout, 32'h5A);
        pop_check("emptypp_pop");

        // clear overrides a same-cycle push
        for (int i = 0; i < 5; i++) push_one(32'h400 + 32'(i));
        check_status("preclr", 5);
        clr    = 1'b1;
        wr_vld = 1'b1;
        wr_din = 32'h77;
        tick();
        clr    = 1'b0;
        wr_vld = 1'b0;
        exp_q.delete();
        check_status("clr", 0);
        push_one(32'h88);
        check_status("postclr", 1);
        check_eq("postclr_head", rd_dout, 32'h88);
        pop_check("postclr_pop");
        check_status("final", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
